// File: rtl/uart_word_writer.sv
// Packs UART bytes little-endian into WORD_BYTES-wide words and writes them to
// consecutive RAM addresses from BASE_ADDR; length is fixed or taken from a 2-byte header.
module uart_word_writer #(
  parameter int ADDR_W     = 16,
  parameter int WORD_BYTES = 1,
  parameter int BASE_ADDR  = 0,
  parameter int LEN_MODE   = 0,
  parameter int NUM_WORDS  = 65536,
  parameter int AUTO_START = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [7:0]              din,
  input  logic                    rx_tick,
  output logic                    wen,
  output logic [ADDR_W-1:0]       addr,
  output logic [8*WORD_BYTES-1:0] dout,
  output logic                    busy,
  output logic                    fin,
  output logic                    err
);

  localparam int DW   = 8 * WORD_BYTES;
  localparam int BC_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [BC_W-1:0] LAST_LANE = BC_W'(WORD_BYTES - 1);
  localparam logic [16:0]     FIXED_LEN = 17'(NUM_WORDS);

  typedef enum logic [2:0] {IDLE, HDR_LO, HDR_HI, RECV, DONE} state_t;

  localparam state_t ARM_STATE = (LEN_MODE != 0) ? HDR_LO : RECV;
  localparam state_t RST_STATE = (AUTO_START != 0) ? ARM_STATE : IDLE;

  state_t            state, state_n;
  logic              rx_q;
  logic [BC_W-1:0]   byte_cnt;
  logic [16:0]       word_cnt;
  logic [DW-1:0]     part;
  logic [DW-1:0]     packed_word;
  logic [15:0]       len;
  logic [16:0]       target;
  logic              byte_ev;
  logic              last_word;
  logic              store, write, hdr_lo, hdr_hi;

  // A strobe held high for many cycles must count as a single byte.
  assign byte_ev   = rx_tick & ~rx_q;
  assign target    = (LEN_MODE != 0) ? {1'b0, len} : FIXED_LEN;
  assign last_word = ((word_cnt + 17'd1) == target);

  always_comb begin
    packed_word = part;
    packed_word[8*int'(byte_cnt) +: 8] = din;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    store   = 1'b0;
    write   = 1'b0;
    hdr_lo  = 1'b0;
    hdr_hi  = 1'b0;
    if (start) begin
      state_n = ARM_STATE;
    end else begin
      case (state)
        IDLE: ;
        HDR_LO: if (byte_ev) begin
          hdr_lo  = 1'b1;
          state_n = HDR_HI;
        end
        HDR_HI: if (byte_ev) begin
          hdr_hi  = 1'b1;
          state_n = ({din, len[7:0]} == 16'd0) ? DONE : RECV;
        end
        RECV: if (byte_ev) begin
          store = 1'b1;
          if (byte_cnt == LAST_LANE) begin
            write = 1'b1;
            if (last_word) state_n = DONE;
          end
        end
        DONE: ;
        default: state_n = IDLE;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RST_STATE;
      rx_q     <= 1'b0;
      byte_cnt <= '0;
      word_cnt <= '0;
      part     <= '0;
      len      <= '0;
      wen      <= 1'b0;
      addr     <= '0;
      dout     <= '0;
      busy     <= 1'b0;
      fin      <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= state_n;
      rx_q  <= rx_tick;
      wen   <= write;
      busy  <= (state_n == HDR_LO) || (state_n == HDR_HI) || (state_n == RECV);
      if (start) begin
        byte_cnt <= '0;
        word_cnt <= '0;
        part     <= '0;
        len      <= '0;
        fin      <= 1'b0;
        err      <= 1'b0;
      end else begin
        if (hdr_lo) len[7:0]  <= din;
        if (hdr_hi) len[15:8] <= din;
        if (store) begin
          part[8*int'(byte_cnt) +: 8] <= din;
          byte_cnt <= write ? '0 : byte_cnt + 1'b1;
        end
        if (write) begin
          dout     <= packed_word;
          addr     <= ADDR_W'(BASE_ADDR) + ADDR_W'(word_cnt);
          word_cnt <= word_cnt + 17'd1;
          if (last_word) fin <= 1'b1;
        end
        // A zero-length header reaches DONE without a write; fin follows one edge later.
        if (state == DONE) fin <= 1'b1;
        if (state == DONE && byte_ev) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_word_writer.sv
// Self-checking bench for uart_word_writer: four parameterisations driven by
// vector tables, with a per-instance scoreboard of expected RAM writes.
module tb_uart_word_writer;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  typedef struct {
    logic [7:0]  din;
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    bit          fin;
  } vec_t;

  logic clk = 1'b0;
  logic rst, rst_w;
  logic [7:0] din;
  logic rx1, rx2, rx4, rxw;
  logic st1, st2, st4, stw;

  logic        w1_wen, w1_busy, w1_fin, w1_err;
  logic [15:0] w1_addr;
  logic [7:0]  w1_dout;
  logic        w2_wen, w2_busy, w2_fin, w2_err;
  logic [15:0] w2_addr;
  logic [15:0] w2_dout;
  logic        w4_wen, w4_busy, w4_fin, w4_err;
  logic [15:0] w4_addr;
  logic [31:0] w4_dout;
  logic        ww_wen, ww_busy, ww_fin, ww_err;
  logic [3:0]  ww_addr;
  logic [7:0]  ww_dout;

  int vectors = 0;
  int miscompares = 0;
  int n1 = 0, n2 = 0, n4 = 0, nw = 0;
  logic p1 = 1'b0, p2 = 1'b0, p4 = 1'b0, pw = 1'b0;
  exp_t q1[$], q2[$], q4[$], qw[$];

  uart_word_writer #(.ADDR_W(16), .WORD_BYTES(1), .BASE_ADDR(0), .LEN_MODE(0),
                     .NUM_WORDS(4), .AUTO_START(1)) u1 (
    .clk(clk), .rst(rst), .start(st1), .din(din), .rx_tick(rx1), .wen(w1_wen),
    .addr(w1_addr), .dout(w1_dout), .busy(w1_busy), .fin(w1_fin), .err(w1_err));

  uart_word_writer #(.ADDR_W(16), .WORD_BYTES(2), .BASE_ADDR(0), .LEN_MODE(1),
                     .NUM_WORDS(65536), .AUTO_START(0)) u2 (
    .clk(clk), .rst(rst), .start(st2), .din(din), .rx_tick(rx2), .wen(w2_wen),
    .addr(w2_addr), .dout(w2_dout), .busy(w2_busy), .fin(w2_fin), .err(w2_err));

  uart_word_writer #(.ADDR_W(16), .WORD_BYTES(4), .BASE_ADDR(8), .LEN_MODE(0),
                     .NUM_WORDS(2), .AUTO_START(1)) u4 (
    .clk(clk), .rst(rst), .start(st4), .din(din), .rx_tick(rx4), .wen(w4_wen),
    .addr(w4_addr), .dout(w4_dout), .busy(w4_busy), .fin(w4_fin), .err(w4_err));

  uart_word_writer #(.ADDR_W(4), .WORD_BYTES(1), .BASE_ADDR(14), .LEN_MODE(0),
                     .NUM_WORDS(4), .AUTO_START(1)) uw (
    .clk(clk), .rst(rst_w), .start(stw), .din(din), .rx_tick(rxw), .wen(ww_wen),
    .addr(ww_addr), .dout(ww_dout), .busy(ww_busy), .fin(ww_fin), .err(ww_err));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard monitors: each wen pops one expected {addr, data}.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (w1_wen) begin
      n1++;
      check("u1_wen_gap", 32'(p1), 32'd0);
      if (q1.size() == 0) check("u1_unexpected_wen", 32'(q1.size()), 32'd1);
      else begin
        e = q1.pop_front();
        check("u1_addr", 32'(w1_addr), e.a);
        check("u1_dout", 32'(w1_dout), e.d);
      end
    end
    p1 = w1_wen;
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (w2_wen) begin
      n2++;
      check("u2_wen_gap", 32'(p2), 32'd0);
      if (q2.size() == 0) check("u2_unexpected_wen", 32'(q2.size()), 32'd1);
      else begin
        e = q2.pop_front();
        check("u2_addr", 32'(w2_addr), e.a);
        check("u2_dout", 32'(w2_dout), e.d);
      end
    end
    p2 = w2_wen;
  end

  always @(negedge clk) begin : mon4
    exp_t e;
    if (w4_wen) begin
      n4++;
      check("u4_wen_gap", 32'(p4), 32'd0);
      if (q4.size() == 0) check("u4_unexpected_wen", 32'(q4.size()), 32'd1);
      else begin
        e = q4.pop_front();
        check("u4_addr", 32'(w4_addr), e.a);
        check("u4_dout", w4_dout, e.d);
      end
    end
    p4 = w4_wen;
  end

  always @(negedge clk) begin : monw
    exp_t e;
    if (ww_wen) begin
      nw++;
      check("uw_wen_gap", 32'(pw), 32'd0);
      if (qw.size() == 0) check("uw_unexpected_wen", 32'(qw.size()), 32'd1);
      else begin
        e = qw.pop_front();
        check("uw_addr", 32'(ww_addr), e.a);
        check("uw_dout", 32'(ww_dout), e.d);
      end
    end
    pw = ww_wen;
  end

  task automatic set_rx(input int which, input logic v);
    case (which)
      1: rx1 = v;
      2: rx2 = v;
      3: rx4 = v;
      default: rxw = v;
    endcase
  endtask

  task automatic set_start(input int which, input logic v);
    case (which)
      1: st1 = v;
      2: st2 = v;
      3: st4 = v;
      default: stw = v;
    endcase
  endtask

  function automatic logic get_fin(input int which);
    case (which)
      1: return w1_fin;
      2: return w2_fin;
      3: return w4_fin;
      default: return ww_fin;
    endcase
  endfunction

  task automatic push(input int which, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    case (which)
      1: q1.push_back(e);
      2: q2.push_back(e);
      3: q4.push_back(e);
      default: qw.push_back(e);
    endcase
  endtask

  task automatic send(input int which, input logic [7:0] b, input int hold);
    @(posedge clk); #1;
    din = b;
    set_rx(which, 1'b1);
    repeat (hold) @(posedge clk);
    #1 set_rx(which, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input int which);
    @(posedge clk); #1 set_start(which, 1'b1);
    @(posedge clk); #1 set_start(which, 1'b0);
  endtask

  task automatic apply(input int which, input vec_t v, input string tag);
    if (v.wr) push(which, v.a, v.d);
    send(which, v.din, 1);
    check({tag, "_fin"}, 32'(get_fin(which)), 32'(v.fin));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t t1[4];
    vec_t t2[8];
    vec_t tw[4];

    for (int i = 0; i < 4; i++) begin
      t1[i] = '{8'h68, 1'b1, 32'(i), 32'h68, (i == 3)};
      tw[i] = '{8'(8'h10 + i), 1'b1, 32'((14 + i) % 16), 32'(8'h10 + i), (i == 3)};
    end
    t2[0] = '{8'h03, 1'b0, 32'd0, 32'h0,    1'b0};
    t2[1] = '{8'h00, 1'b0, 32'd0, 32'h0,    1'b0};
    t2[2] = '{8'h11, 1'b0, 32'd0, 32'h0,    1'b0};
    t2[3] = '{8'h22, 1'b1, 32'd0, 32'h2211, 1'b0};
    t2[4] = '{8'h33, 1'b0, 32'd0, 32'h0,    1'b0};
    t2[5] = '{8'h44, 1'b1, 32'd1, 32'h4433, 1'b0};
    t2[6] = '{8'h55, 1'b0, 32'd0, 32'h0,    1'b0};
    t2[7] = '{8'h66, 1'b1, 32'd2, 32'h6655, 1'b1};

    rst = 1'b1; rst_w = 1'b1; din = 8'h00;
    rx1 = 0; rx2 = 0; rx4 = 0; rxw = 0;
    st1 = 0; st2 = 0; st4 = 0; stw = 0;

    // Reset state
    #2;
    check("rst_u1_ctl", {28'd0, w1_wen, w1_busy, w1_fin, w1_err}, 32'd0);
    check("rst_u1_data", {8'd0, w1_addr, w1_dout}, 32'd0);
    check("rst_u2_ctl", {28'd0, w2_wen, w2_busy, w2_fin, w2_err}, 32'd0);
    check("rst_u4_data", w4_dout, 32'd0);
    check("rst_uw_ctl", {28'd0, ww_wen, ww_busy, ww_fin, ww_err}, 32'd0);
    @(posedge clk); #1 rst = 1'b0; rst_w = 1'b0;
    @(posedge clk); #1;
    check("u1_autostart_busy", 32'(w1_busy), 32'd1);
    check("u2_idle_busy", 32'(w2_busy), 32'd0);

    // Byte mode, fixed length 4
    for (int i = 0; i < 4; i++) apply(1, t1[i], $sformatf("u1_t1_%0d", i));
    check("u1_done_busy", 32'(w1_busy), 32'd0);
    check("u1_writes", 32'(n1), 32'd4);

    // Held strobe counts once
    pulse_start(1);
    check("u1_restart_fin", {30'd0, w1_fin, w1_busy}, 32'd1);
    push(1, 32'd0, 32'hA5);
    send(1, 8'hA5, 5);
    repeat (3) @(posedge clk);
    #1;
    check("u1_held_writes", 32'(n1), 32'd5);
    check("u1_held_fin_err", {30'd0, w1_fin, w1_err}, 32'd0);

    // Header mode, 2-byte words
    send(2, 8'h77, 1);
    check("u2_idle_ignored", 32'(n2), 32'd0);
    pulse_start(2);
    for (int i = 0; i < 8; i++) apply(2, t2[i], $sformatf("u2_t2_%0d", i));
    check("u2_done_busy_err", {30'd0, w2_busy, w2_err}, 32'd0);
    send(2, 8'h99, 1);
    check("u2_overrun_err", 32'(w2_err), 32'd1);
    check("u2_overrun_no_wen", 32'(n2), 32'd3);

    // Zero-length header: fin two cycles after the second byte event
    pulse_start(2);
    check("u2_restart_err", {30'd0, w2_fin, w2_err}, 32'd0);
    send(2, 8'h00, 1);
    @(posedge clk); #1 din = 8'h00; rx2 = 1'b1;
    @(posedge clk); #1;
    check("u2_zero_fin_early", 32'(w2_fin), 32'd0);
    rx2 = 1'b0;
    @(posedge clk); #1;
    check("u2_zero_fin", 32'(w2_fin), 32'd1);
    check("u2_zero_busy", 32'(w2_busy), 32'd0);
    check("u2_zero_no_wen", 32'(n2), 32'd3);

    // Start and byte on the same edge: byte is discarded
    @(posedge clk); #1 din = 8'h05; rx2 = 1'b1; st2 = 1'b1;
    @(posedge clk); #1 rx2 = 1'b0; st2 = 1'b0;
    check("u2_start_win", {29'd0, w2_busy, w2_fin, w2_err}, 32'd4);
    send(2, 8'h01, 1);
    send(2, 8'h00, 1);
    send(2, 8'hAB, 1);
    push(2, 32'd0, 32'hCDAB);
    send(2, 8'hCD, 1);
    check("u2_one_word_fin", 32'(w2_fin), 32'd1);

    // 4-byte words: abort discards partial word
    send(3, 8'hAA, 1);
    send(3, 8'hBB, 1);
    pulse_start(3);
    send(3, 8'h01, 1);
    send(3, 8'h02, 1);
    send(3, 8'h03, 1);
    push(3, 32'd8, 32'h04030201);
    send(3, 8'h04, 1);
    check("u4_mid_fin_busy", {30'd0, w4_fin, w4_busy}, 32'd1);
    for (int i = 5; i <= 8; i++) begin
      if (i == 8) push(3, 32'd9, 32'h08070605);
      send(3, 8'(i), 1);
    end
    check("u4_fin", 32'(w4_fin), 32'd1);

    // Address wrap in a 4-bit space
    for (int i = 0; i < 4; i++) apply(4, tw[i], $sformatf("uw_tw_%0d", i));
    repeat (2) @(posedge clk);
    #1;
    check("uw_addr_hold", 32'(ww_addr), 32'd1);

    // Reset mid-transfer
    pulse_start(4);
    push(4, 32'd14, 32'h21);
    send(4, 8'h21, 1);
    push(4, 32'd15, 32'h22);
    send(4, 8'h22, 1);
    @(posedge clk); #1 din = 8'h99; rxw = 1'b1;
    #2 rst_w = 1'b1;
    #1;
    check("uw_rst_ctl", {28'd0, ww_wen, ww_busy, ww_fin, ww_err}, 32'd0);
    check("uw_rst_data", {20'd0, ww_addr, ww_dout}, 32'd0);
    rxw = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_w = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("uw_rst_no_wen", 32'(nw), 32'd6);
    check("uw_rearmed", {30'd0, ww_busy, ww_fin}, 32'd2);

    check("q1_pending", 32'(q1.size()), 32'd0);
    check("q2_pending", 32'(q2.size()), 32'd0);
    check("q4_pending", 32'(q4.size()), 32'd0);
    check("qw_pending", 32'(qw.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
